spram_arbiter: RTL
==================

# spram_arbiter

Two-port arbiter and sequencer in front of the single-port 32-bit SPRAM block. Shares the memory between the instruction-fetch port (A, read-only) and the load/store port (B, read/write), alternating grants round-robin on contention. Sub-word stores are turned into read-modify-write sequences, since the SPRAM write path always writes full words. Sits between the CPU core and the SPRAM instance.

## Interface

- `ADDR_W`, 15: byte-address width, passed unmodified to the SPRAM.
- `clk` in 1: single clock for the block and the SPRAM.
- `rst` in 1: synchronous, active-high reset.
- `a_rd_en` in 1: port A read request; held until granted.
- `a_addr` in ADDR_W: port A byte address.
- `a_gnt` out 1: combinational; request accepted this cycle.
- `a_rd_data` out 32: read data, qualified by `a_rd_valid`.
- `a_rd_valid` out 1: one-cycle strobe for port A read data.
- `b_rd_en` in 1: port B read request; held until granted.
- `b_wr_en` in 1: port B write request; held until granted. Never asserted together with `b_rd_en`.
- `b_addr` in ADDR_W: port B byte address.
- `b_wr_data` in 32: port B write data.
- `b_wr_mask` in 4: byte enables; bit i selects bits [8i+7:8i].
- `b_gnt` out 1: combinational; request accepted this cycle.
- `b_rd_data` out 32 / `b_rd_valid` out 1: port B read data and strobe.
- `b_wr_done` out 1: one-cycle strobe marking write completion.
- `mem_rd_en`, `mem_wr_en` out 1; `mem_addr` out ADDR_W; `mem_wr_data` out 32: SPRAM command outputs (combinational).
- `mem_rd_data` in 32; `mem_rd_valid` in 1: SPRAM returns data and `rd_valid` one cycle after `rd_en`.

## Operation

- States: IDLE, RMW_RD, RMW_WR.
- IDLE arbitration:
  - Request A means `a_rd_en`. Request B means `b_rd_en | b_wr_en`.
  - A single requester is granted.
  - If both request, grant goes to the port not recorded in `last` (1-bit register; 0 = A last, 1 = B last). `last` updates on every grant.
- Granted read: `mem_rd_en=1`, `mem_addr` from the granted port. An `owner` register records the port. When `mem_rd_valid` arrives next cycle, `mem_rd_data` is routed to that port's `*_rd_data`, and only that port's `*_rd_valid` asserts.
- Granted write, mask 1111: `mem_wr_en=1`, data `b_wr_data`. `b_wr_done` asserts the next cycle. State stays IDLE.
- Granted write, mask 0000: no memory access. `b_wr_done` asserts the next cycle.
- Granted write, partial mask (RMW build only):
  - The grant cycle issues `mem_rd_en` and latches address, data and mask. Next state RMW_RD.
  - RMW_RD: `mem_rd_data` is valid. Merge per byte: masked bytes from the latched data, others from `mem_rd_data`. Issue `mem_wr_en` with the merged word. Next state RMW_WR. No grants.
  - RMW_WR: `b_wr_done` asserts. No memory command. Grants resume next cycle (back to IDLE).
  - The RMW internal read never drives `a_rd_valid` or `b_rd_valid`.
- `a_gnt` and `b_gnt` are 0 outside IDLE.

## Timing

- Reset values: state IDLE, `last=1` (A wins the first tie), `owner=A`; all `*_valid`, `b_wr_done`, `a_gnt`, `b_gnt` and `mem_*_en` are 0.
- Read latency: grant at cycle T, `*_rd_valid` at T+1.
- Full-word write: grant at T, `b_wr_done` at T+1.
- RMW write: grant at T, memory write at T+1, `b_wr_done` at T+2. Port A stalls for T+1 and T+2.
- Back-to-back: a new grant is allowed every cycle in IDLE, so one access per cycle with both ports busy.
- Reset asserted mid-RMW: the sequence is abandoned. No memory write, no `b_wr_done`. The block is in IDLE the cycle after reset deasserts.
- A `mem_rd_valid` arriving during reset, or in the cycle after it, is dropped.

## Configuration

- `SPRAM_ARB_RMW_EN` defined: partial-mask writes run the RMW sequence described above.
- Not defined:
  - `b_wr_mask` is ignored. Every write is a full-word write completing in one cycle.
  - States RMW_RD and RMW_WR are not built.

## Test plan

- A read only, `a_addr=0x0010`, memory word 0xDEADBEEF → `a_gnt` at T, `a_rd_valid` with 0xDEADBEEF at T+1, `b_rd_valid` stays 0.
- A and B reads asserted together for 4 cycles after reset → grants in order A, B, A, B; each read's data returns to the correct port.
- B write 0x12345678, mask 1111, to 0x0040; then B read of 0x0040 → `b_wr_done` at T+1, read returns 0x12345678.
- RMW build: word 0x12345678, then write 0xAABBCCDD with mask 0101 → `mem_wr_en` at T+1, `b_wr_done` at T+2, `a_gnt` held 0 during T+1 and T+2, readback 0x12BB56DD.
- RMW with `rst` pulsed at T+1 → no `mem_wr_en`, no `b_wr_done`, memory keeps 0x12345678.
- Non-RMW build, same write with mask 0101 → `b_wr_done` at T+1, readback 0xAABBCCDD.

Source files
------------

// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port 32-bit SPRAM.
// Define SPRAM_ARB_RMW_EN to turn partial-mask stores into read-modify-write sequences.
`timescale 1ns/1ps
module spram_arbiter #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_rd_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic [31:0]       a_rd_data,
  output logic              a_rd_valid,
  input  logic              b_rd_en,
  input  logic              b_wr_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wr_data,
  input  logic [3:0]        b_wr_mask,
  output logic              b_gnt,
  output logic [31:0]       b_rd_data,
  output logic              b_rd_valid,
  output logic              b_wr_done,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid
);

  logic last_reg;     // 0: A granted last, 1: B granted last
  logic owner_reg;    // 0: A, 1: B
  logic pend_reg;     // a port read was issued last cycle
  logic done_reg;
  logic req_a, req_b, pick_b, in_idle;
  logic wr_full, wr_partial;

  assign req_a  = a_rd_en;
  assign req_b  = b_rd_en | b_wr_en;
  assign pick_b = req_b & (~req_a | ~last_reg);

`ifdef SPRAM_ARB_RMW_EN
  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;
  state_t            state_reg;
  logic [ADDR_W-1:0] rmw_addr_reg;
  logic [31:0]       rmw_data_reg;
  logic [3:0]        rmw_mask_reg;
  logic [31:0]       merged;

  assign in_idle    = (state_reg == IDLE) & ~rst;
  assign wr_full    = (b_wr_mask == 4'hF);
  assign wr_partial = (b_wr_mask != 4'hF) & (b_wr_mask != 4'h0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi+7:8*gi] = rmw_mask_reg[gi] ? rmw_data_reg[8*gi+7:8*gi]
                                                   : mem_rd_data[8*gi+7:8*gi];
  end
`else
  logic unused_mask;
  assign unused_mask = ^b_wr_mask;
  assign in_idle     = ~rst;
  assign wr_full     = 1'b1;
  assign wr_partial  = 1'b0;
`endif

  assign a_gnt = in_idle & req_a & ~pick_b;
  assign b_gnt = in_idle & pick_b;

  always_comb begin
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = a_addr;
    mem_wr_data = b_wr_data;
    if (a_gnt) begin
      mem_rd_en = 1'b1;
    end else if (b_gnt) begin
      mem_addr = b_addr;
      if (b_rd_en)         mem_rd_en = 1'b1;
      else if (wr_full)    mem_wr_en = 1'b1;
      else if (wr_partial) mem_rd_en = 1'b1;  // fetch old word for the merge
    end
`ifdef SPRAM_ARB_RMW_EN
    if (state_reg == RMW_RD && !rst) begin
      mem_wr_en   = 1'b1;
      mem_addr    = rmw_addr_reg;
      mem_wr_data = merged;
    end
`endif
  end

  // Only port reads set pend_reg, so RMW fetches never surface as read data.
  assign a_rd_data  = mem_rd_data;
  assign b_rd_data  = mem_rd_data;
  assign a_rd_valid = mem_rd_valid & pend_reg & ~owner_reg & ~rst;
  assign b_rd_valid = mem_rd_valid & pend_reg & owner_reg & ~rst;
  assign b_wr_done  = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      pend_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SPRAM_ARB_RMW_EN
      state_reg    <= IDLE;
      rmw_addr_reg <= '0;
      rmw_data_reg <= '0;
      rmw_mask_reg <= '0;
`endif
    end else begin
      pend_reg <= a_gnt | (b_gnt & b_rd_en);
      done_reg <= b_gnt & b_wr_en & ~wr_partial;
      if (a_gnt) begin
        last_reg  <= 1'b0;
        owner_reg <= 1'b0;
      end else if (b_gnt) begin
        last_reg <= 1'b1;
        if (b_rd_en) owner_reg <= 1'b1;
      end
`ifdef SPRAM_ARB_RMW_EN
      case (state_reg)
        IDLE: begin
          if (b_gnt && b_wr_en && wr_partial) begin
            state_reg    <= RMW_RD;
            rmw_addr_reg <= b_addr;
            rmw_data_reg <= b_wr_data;
            rmw_mask_reg <= b_wr_mask;
          end
        end
        RMW_RD: begin
          state_reg <= RMW_WR;
          done_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
`endif
    end
  end

endmodule
